// File: rtl/picobello_dummy_tile_slv.sv
// AXI4 error responder for empty mesh positions: answers every read with a poison burst and
// drains every write, both with DECERR. Optional error counter: PICOBELLO_DUMMY_TILE_ERRCNT_EN.

package picobello_dummy_tile_pkg;
  localparam int unsigned IdW   = 4;
  localparam int unsigned AddrW = 48;
  localparam int unsigned DataW = 64;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
  } ax_chan_t;

  typedef struct packed {
    logic last;
  } w_chan_t;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic [1:0]     resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    logic [1:0]       resp;
    logic             last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_rsp_t;
endpackage

module picobello_dummy_tile_slv #(
  parameter type         axi_req_t  = picobello_dummy_tile_pkg::axi_req_t,
  parameter type         axi_rsp_t  = picobello_dummy_tile_pkg::axi_rsp_t,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned IdWidth    = 4,
  parameter int unsigned MaxWrTxns  = 4,
  parameter logic [31:0] PoisonWord = 32'hBADCAB1E
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        test_mode_i,
  input  axi_req_t    axi_req_i,
  output axi_rsp_t    axi_rsp_o,
  output logic [31:0] err_cnt_o
);

  localparam logic [1:0]  RespDecErr = 2'b11;
  localparam int unsigned PtrW       = (MaxWrTxns > 1) ? $clog2(MaxWrTxns) : 1;
  localparam int unsigned CntW       = $clog2(MaxWrTxns + 1);

  typedef enum logic { W_IDLE, W_DRAIN } w_state_e;
  typedef enum logic { R_IDLE, R_BURST } r_state_e;

  // Handshake rule on every channel: a beat transfers on the rising edge where valid and ready
  // are both high; valid/payload driven here depend only on flops, never on the incoming ready.
  w_state_e           w_state_q;
  logic               aw_en_q, w_ready_q;
  logic [IdWidth-1:0] w_id_q;
  logic               aw_ready, aw_hs, w_hs, b_hs;

  r_state_e           r_state_q;
  logic               ar_ready_q, r_valid_q, r_last_q;
  logic [IdWidth-1:0] r_id_q;
  logic [8:0]         r_cnt_q;
  logic               ar_hs, r_hs;

  logic [IdWidth-1:0] mem_q [MaxWrTxns];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    cnt_q;
  logic               fifo_full, fifo_empty, push;

  assign fifo_full  = (cnt_q == CntW'(MaxWrTxns));
  assign fifo_empty = (cnt_q == '0);

  assign aw_ready = aw_en_q & ~fifo_full;
  assign aw_hs    = axi_req_i.aw_valid & aw_ready;
  assign w_hs     = axi_req_i.w_valid & w_ready_q;
  assign push     = w_hs & axi_req_i.w.last;
  assign b_hs     = ~fifo_empty & axi_req_i.b_ready;
  assign ar_hs    = axi_req_i.ar_valid & ar_ready_q;
  assign r_hs     = r_valid_q & axi_req_i.r_ready;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxWrTxns - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin : p_wr_fsm
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      aw_en_q   <= 1'b0;
      w_ready_q <= 1'b0;
      w_id_q    <= '0;
    end else begin
      unique case (w_state_q)
        W_IDLE: begin
          aw_en_q <= 1'b1;
          if (aw_hs) begin
            w_id_q    <= axi_req_i.aw.id;
            aw_en_q   <= 1'b0;
            w_ready_q <= 1'b1;
            w_state_q <= W_DRAIN;
          end
        end
        W_DRAIN: begin
          // The burst ends on w.last alone; the AW length is deliberately not trusted.
          if (push) begin
            aw_en_q   <= 1'b1;
            w_ready_q <= 1'b0;
            w_state_q <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Pending-B FIFO; AW is held off while full, so a push never meets a full FIFO without a pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin : p_b_fifo
    if (!rst_ni) begin
      for (int i = 0; i < MaxWrTxns; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= w_id_q;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (b_hs) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CntW'(push) - CntW'(b_hs);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : p_rd_fsm
    if (!rst_ni) begin
      r_state_q  <= R_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_id_q     <= '0;
      r_cnt_q    <= '0;
    end else begin
      unique case (r_state_q)
        R_IDLE: begin
          ar_ready_q <= 1'b1;
          if (ar_hs) begin
            r_id_q     <= axi_req_i.ar.id;
            r_cnt_q    <= {1'b0, axi_req_i.ar.len};
            r_last_q   <= (axi_req_i.ar.len == 8'd0);
            r_valid_q  <= 1'b1;
            ar_ready_q <= 1'b0;
            r_state_q  <= R_BURST;
          end
        end
        R_BURST: begin
          if (r_hs) begin
            if (r_last_q) begin
              r_valid_q  <= 1'b0;
              r_last_q   <= 1'b0;
              ar_ready_q <= 1'b1;
              r_state_q  <= R_IDLE;
            end else begin
              r_cnt_q  <= r_cnt_q - 9'd1;
              r_last_q <= (r_cnt_q == 9'd1);
            end
          end
        end
      endcase
    end
  end

`ifdef PICOBELLO_DUMMY_TILE_ERRCNT_EN
  logic [31:0] err_cnt_q;
  logic [32:0] err_sum;
  logic        r_last_hs;

  assign r_last_hs = r_hs & r_last_q;
  assign err_sum   = {1'b0, err_cnt_q} + {32'd0, b_hs} + {32'd0, r_last_hs};

  always_ff @(posedge clk_i or negedge rst_ni) begin : p_err_cnt
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else if (b_hs || r_last_hs) begin
      err_cnt_q <= err_sum[32] ? '1 : err_sum[31:0];
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif

  always_comb begin
    axi_rsp_o          = '0;
    axi_rsp_o.aw_ready = aw_ready;
    axi_rsp_o.w_ready  = w_ready_q;
    axi_rsp_o.ar_ready = ar_ready_q;
    axi_rsp_o.b_valid  = ~fifo_empty;
    axi_rsp_o.b.id     = fifo_empty ? '0 : mem_q[rd_ptr_q];
    axi_rsp_o.b.resp   = fifo_empty ? 2'b00 : RespDecErr;
    axi_rsp_o.r_valid  = r_valid_q;
    axi_rsp_o.r.id     = r_valid_q ? r_id_q : '0;
    axi_rsp_o.r.data   = r_valid_q ? {(DataWidth / 32){PoisonWord}} : '0;
    axi_rsp_o.r.resp   = r_valid_q ? RespDecErr : 2'b00;
    axi_rsp_o.r.last   = r_last_q;
  end

  logic unused_bits;
  assign unused_bits = ^{test_mode_i, axi_req_i.aw.addr, axi_req_i.aw.len, axi_req_i.ar.addr};

endmodule

// File: tb/tb_picobello_dummy_tile_slv.sv
// Bench for picobello_dummy_tile_slv: vector table, directed corner sequences and random
// read/write traffic checked against a transaction-level model.
module tb_picobello_dummy_tile_slv;
  import picobello_dummy_tile_pkg::*;

  localparam logic [63:0] POISON = 64'hBADCAB1E_BADCAB1E;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        test_mode = 1'b0;
  axi_req_t    req;
  axi_rsp_t    rsp;
  logic [31:0] err_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int model_err = 0;
  logic [3:0] exp_q[$];

  picobello_dummy_tile_slv dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .test_mode_i(test_mode),
    .axi_req_i  (req),
    .axi_rsp_o  (rsp),
    .err_cnt_o  (err_cnt)
  );

  // ---- clock / watchdog ----
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- scoreboard helpers ----
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_err();
`ifdef PICOBELLO_DUMMY_TILE_ERRCNT_EN
    return model_err;
`else
    return 32'd0;
`endif
  endfunction

  // ---- driver tasks (all driving and sampling on the falling edge) ----
  task automatic do_read(input logic [3:0] id, input logic [7:0] len, input bit rnd,
                         input int exp_beats);
    int beats = 0;
    int guard = 0;
    bit done  = 0;
    @(negedge clk);
    req.ar_valid = 1'b1;
    req.ar.id    = id;
    req.ar.len   = len;
    req.ar.addr  = 48'($urandom);
    while (!rsp.ar_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("ar_accept", rsp.ar_ready, 1'b1);
    if (!rsp.ar_ready) begin
      req.ar_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req.ar_valid = 1'b0;
    check("r_latency", rsp.r_valid, 1'b1);
    guard = 0;
    while (!done && guard < 2000) begin
      req.r_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rsp.r_valid) begin
        check("r_beat", {rsp.r.id, rsp.r.data, rsp.r.resp, rsp.r.last},
              {id, POISON, 2'b11, 1'(beats == exp_beats - 1)});
        if (req.r_ready) begin
          beats++;
          if (rsp.r.last) done = 1;
        end
      end
      @(negedge clk);
      guard++;
    end
    req.r_ready = 1'b0;
    if (done) model_err++;
    check("r_count", beats, exp_beats);
    check("r_idle", {rsp.r_valid, rsp.ar_ready}, 2'b01);
  endtask

  task automatic do_write(input logic [3:0] id, input int nbeats);
    int guard = 0;
    @(negedge clk);
    req.aw_valid = 1'b1;
    req.aw.id    = id;
    req.aw.len   = 8'(nbeats - 1);
    req.aw.addr  = 48'($urandom);
    while (!rsp.aw_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("aw_accept", rsp.aw_ready, 1'b1);
    if (!rsp.aw_ready) begin
      req.aw_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req.aw_valid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      req.w_valid = 1'b1;
      req.w.last  = (b == nbeats - 1);
      guard = 0;
      while (!rsp.w_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      check("w_accept", rsp.w_ready, 1'b1);
      @(negedge clk);
      req.w_valid = 1'b0;
      req.w.last  = 1'b0;
    end
    exp_q.push_back(id);
  endtask

  task automatic drain_b(input bit rnd);
    int guard = 0;
    logic [3:0] e;
    while (exp_q.size() > 0 && guard < 500) begin
      req.b_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rsp.b_valid && req.b_ready) begin
        e = exp_q.pop_front();
        check("b_rsp", {rsp.b.id, rsp.b.resp}, {e, 2'b11});
        model_err++;
      end
      @(negedge clk);
      guard++;
    end
    req.b_ready = 1'b0;
    check("b_drained", exp_q.size(), 0);
    check("b_empty", rsp.b_valid, 1'b0);
  endtask

  // ---- vector tables ----
  typedef struct {
    logic [3:0] id;
    logic [7:0] len;
    int         exp_beats;
  } rd_vec_t;

  typedef struct {
    logic [3:0] id;
    int         beats;
  } wr_vec_t;

  rd_vec_t rd_tab[5];
  wr_vec_t wr_tab[3];

  initial begin
    int cnt;
    int rlen;
    logic [3:0] e;

    rd_tab[0] = '{4'd3,  8'd0,   1};
    rd_tab[1] = '{4'd5,  8'd1,   2};
    rd_tab[2] = '{4'd15, 8'd3,   4};
    rd_tab[3] = '{4'd0,  8'd15,  16};
    rd_tab[4] = '{4'd10, 8'd255, 256};
    wr_tab[0] = '{4'd1,  1};
    wr_tab[1] = '{4'd14, 3};
    wr_tab[2] = '{4'd6,  8};

    // ---- reset ----
    req = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rsp", rsp, '0);
    check("reset_errcnt", err_cnt, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", {rsp.ar_ready, rsp.aw_ready, rsp.w_ready, rsp.b_valid, rsp.r_valid},
          5'b11000);

    // ---- table-driven reads and writes ----
    foreach (rd_tab[i]) do_read(rd_tab[i].id, rd_tab[i].len, 1'b0, rd_tab[i].exp_beats);
    foreach (wr_tab[i]) begin
      do_write(wr_tab[i].id, wr_tab[i].beats);
      check("b_latency", {rsp.b_valid, rsp.b.id, rsp.b.resp}, {1'b1, wr_tab[i].id, 2'b11});
      drain_b(1'b0);
    end

    // ---- long burst with random back-pressure ----
    do_read(4'd9, 8'd255, 1'b1, 256);

    // ---- B FIFO fill, block, release ----
    for (int i = 0; i < 4; i++) do_write(4'(i), 2);
    @(negedge clk);
    req.aw_valid = 1'b1;
    req.aw.id    = 4'd4;
    req.aw.len   = 8'd1;
    repeat (3) @(negedge clk);
    check("aw_full_block", rsp.aw_ready, 1'b0);
    req.b_ready = 1'b1;
    e = exp_q.pop_front();
    check("b_first_pop", {rsp.b_valid, rsp.b.id, rsp.b.resp}, {1'b1, e, 2'b11});
    model_err++;
    @(negedge clk);
    req.b_ready = 1'b0;
    check("aw_reopen", rsp.aw_ready, 1'b1);
    req.aw_valid = 1'b0;
    do_write(4'd4, 2);
    drain_b(1'b1);

    // ---- concurrent read and write ----
    fork
      do_read(4'd6, 8'd3, 1'b0, 4);
      do_write(4'd9, 1);
    join
    drain_b(1'b0);

    // ---- random traffic ----
    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          rlen = $urandom_range(0, 15);
          do_read(4'($urandom), 8'(rlen), 1'b1, rlen + 1);
        end
        1: begin
          do_write(4'($urandom), $urandom_range(1, 4));
          drain_b(1'b1);
        end
        default: begin
          rlen = $urandom_range(0, 7);
          fork
            do_read(4'($urandom_range(0, 15)), 8'(rlen), 1'b1, rlen + 1);
            do_write(4'($urandom_range(0, 15)), $urandom_range(1, 4));
          join
          drain_b(1'b1);
        end
      endcase
    end

    check("errcnt_total", err_cnt, exp_err());

    // ---- B and R-last completing in the same cycle ----
    do_write(4'd2, 1);
    @(negedge clk);
    req.ar_valid = 1'b1;
    req.ar.id    = 4'd4;
    req.ar.len   = 8'd0;
    cnt = 0;
    while (!rsp.ar_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    @(negedge clk);
    req.ar_valid = 1'b0;
    check("dual_valid", {rsp.r_valid, rsp.r.last, rsp.b_valid}, 3'b111);
    req.r_ready = 1'b1;
    req.b_ready = 1'b1;
    e = exp_q.pop_front();
    check("dual_b", {rsp.b.id, rsp.b.resp}, {e, 2'b11});
    model_err += 2;
    @(negedge clk);
    req.r_ready = 1'b0;
    req.b_ready = 1'b0;
    check("errcnt_dual", err_cnt, exp_err());

    // ---- reset in the middle of a burst, with a B pending ----
    do_write(4'd5, 1);
    @(negedge clk);
    req.ar_valid = 1'b1;
    req.ar.id    = 4'd1;
    req.ar.len   = 8'd7;
    req.r_ready  = 1'b1;
    @(negedge clk);
    req.ar_valid = 1'b0;
    @(negedge clk);
    check("mid_burst_valid", rsp.r_valid, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async", {rsp.r_valid, rsp.ar_ready, rsp.b_valid, rsp.aw_ready}, 4'b0000);
    check("rst_errcnt", err_cnt, 32'd0);
    exp_q.delete();
    model_err = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_ready", {rsp.ar_ready, rsp.aw_ready, rsp.b_valid}, 3'b110);
    cnt = 0;
    repeat (8) begin
      if (rsp.r_valid || rsp.b_valid) cnt++;
      @(negedge clk);
    end
    req.r_ready = 1'b0;
    check("no_residual", cnt, 0);
    do_read(4'd7, 8'd2, 1'b0, 3);
    check("errcnt_after_rst", err_cnt, exp_err());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
